// File: rtl/ddr3_traffic_gen_pkg.sv
// Shared definitions for the DDR3 memory test path: FSM state encoding and the
// deterministic data pattern that both the traffic generator and the read checker use.
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic [63:0] PATTERN_SEED = 64'hdeadfadebabebeef;

    function automatic logic [63:0] pattern(input logic [63:0] idx);
        return PATTERN_SEED ^ idx;
    endfunction

endpackage

// File: rtl/ddr3_traffic_gen_if.sv
// Avalon-MM local interface between the traffic generator (master) and the
// DDR3 controller (slave).
interface ddr3_traffic_gen_if #(
    parameter int ADDR_WIDTH = 25
) ();

    logic                  avl_ready;
    logic                  avl_rdata_valid;
    logic                  avl_burstbegin;
    logic [ADDR_WIDTH-1:0] avl_addr;
    logic [63:0]           avl_wdata;
    logic [7:0]            avl_be;
    logic [2:0]            avl_size;
    logic                  avl_write_req;
    logic                  avl_read_req;

    modport master (
        input  avl_ready, avl_rdata_valid,
        output avl_burstbegin, avl_addr, avl_wdata, avl_be, avl_size,
        output avl_write_req, avl_read_req
    );

    modport slave (
        output avl_ready, avl_rdata_valid,
        input  avl_burstbegin, avl_addr, avl_wdata, avl_be, avl_size,
        input  avl_write_req, avl_read_req
    );

endinterface

// File: rtl/ddr3_traffic_gen.sv
// DDR3 traffic generator: after calibration writes 2^COUNT_WIDTH pattern words, then reads them back.
// Optional read-credit limiting is enabled by defining DDR3_TRAFFIC_GEN_READ_CREDIT_EN.
module ddr3_traffic_gen
    import ddr3_test_pkg::*;
#(
    parameter int COUNT_WIDTH     = 24,
    parameter int ADDR_WIDTH      = 25,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ddr3_init_done,
    input  logic               ddr3_cal_success,
    input  logic               ddr3_cal_fail,
    ddr3_traffic_gen_if.master avl,
    output logic               is_finished,
    output logic               fail
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_idx;
    logic [COUNT_WIDTH-1:0] w_idx_next;
    logic                   r_fresh;
    logic                   w_fresh_next;
    logic                   r_is_finished;
    logic                   r_fail;
    logic                   w_req_wr;
    logic                   w_req_rd;
    logic                   w_req_any;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_rd_allow;
    logic                   w_rd_finish;

`ifdef DDR3_TRAFFIC_GEN_READ_CREDIT_EN
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] w_out_next;
    logic          r_rd_all;
    logic          w_rd_acc;

    // Credit counter next value; a stray rdata_valid at zero is not allowed to underflow.
    always_comb begin
        w_out_next = r_outstanding;
        w_rd_acc   = w_accept && w_req_rd;
        case ({w_rd_acc, avl.avl_rdata_valid})
            2'b10:   w_out_next = r_outstanding + OW'(1);
            2'b01:   w_out_next = (r_outstanding == OW'(0)) ? OW'(0) : r_outstanding - OW'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    // Credit counter and last-read-issued flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= OW'(0);
            r_rd_all      <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_rd_all      <= r_rd_all || (w_rd_acc && w_last);
        end
    end

    assign w_rd_allow  = !r_rd_all && (r_outstanding != OW'(MAX_OUTSTANDING));
    assign w_rd_finish = ((w_accept && w_last) || r_rd_all) && (w_out_next == OW'(0));
`else
    logic w_unused;

    assign w_unused    = avl.avl_rdata_valid | (MAX_OUTSTANDING < 1);
    assign w_rd_allow  = 1'b1;
    assign w_rd_finish = w_accept && w_last;
`endif

    assign w_req_wr  = (r_state == WRITE);
    assign w_req_rd  = (r_state == READ) && w_rd_allow;
    assign w_req_any = w_req_wr || w_req_rd;
    assign w_accept  = w_req_any && avl.avl_ready;
    assign w_last    = &r_idx;

    assign avl.avl_write_req  = w_req_wr;
    assign avl.avl_read_req   = w_req_rd;
    assign avl.avl_burstbegin = w_req_any && r_fresh;
    assign avl.avl_addr       = ADDR_WIDTH'(r_idx);
    assign avl.avl_wdata      = w_req_wr ? pattern(64'(r_idx)) : 64'h0;
    assign avl.avl_be         = 8'hff;
    assign avl.avl_size       = 3'd1;
    assign is_finished        = r_is_finished;
    assign fail               = r_fail;

    // Next state, next index and the first-presentation flag.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            WAIT_INIT: begin
                if (ddr3_init_done && ddr3_cal_success) begin
                    w_state_next = WRITE;
                end else if (ddr3_init_done && ddr3_cal_fail) begin
                    w_state_next = ERROR;
                end else begin
                    w_state_next = WAIT_INIT;
                end
            end
            WRITE: begin
                if (w_accept) begin
                    w_idx_next   = r_idx + COUNT_WIDTH'(1);
                    w_state_next = w_last ? READ : WRITE;
                end else begin
                    w_state_next = WRITE;
                end
            end
            READ: begin
                if (w_accept) begin
                    w_idx_next = r_idx + COUNT_WIDTH'(1);
                end else begin
                    w_idx_next = r_idx;
                end
                w_state_next = w_rd_finish ? DONE : READ;
            end
            DONE:    w_state_next = DONE;
            ERROR:   w_state_next = ERROR;
            default: w_state_next = WAIT_INIT;
        endcase

        if (w_accept) begin
            w_fresh_next = 1'b1;
        end else if (w_req_any) begin
            w_fresh_next = 1'b0;
        end else if ((r_state == WAIT_INIT) && (w_state_next == WRITE)) begin
            w_fresh_next = 1'b1;
        end else begin
            w_fresh_next = r_fresh;
        end
    end

    // State, index and sticky status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= WAIT_INIT;
            r_idx         <= '0;
            r_fresh       <= 1'b1;
            r_is_finished <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_fresh       <= w_fresh_next;
            r_is_finished <= r_is_finished || (r_state == DONE) || (r_state == ERROR);
            r_fail        <= r_fail || (r_state == ERROR);
        end
    end

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Scoreboard bench for ddr3_traffic_gen with COUNT_WIDTH=3; credit tests run when
// DDR3_TRAFFIC_GEN_READ_CREDIT_EN is defined.
module tb_ddr3_traffic_gen;

    localparam int CW = 3;
    localparam int AW = 4;
    localparam int MO = 2;
`ifdef DDR3_TRAFFIC_GEN_READ_CREDIT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done = 1'b0;
    logic cal_succ = 1'b0;
    logic cal_fail = 1'b0;
    logic is_finished;
    logic fail;

    ddr3_traffic_gen_if #(.ADDR_WIDTH(AW)) avl ();

    ddr3_traffic_gen #(
        .COUNT_WIDTH(CW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .ddr3_init_done(init_done),
        .ddr3_cal_success(cal_succ), .ddr3_cal_fail(cal_fail),
        .avl(avl), .is_finished(is_finished), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [AW-1:0] addr;
        logic [63:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 0;
    int   rv_mode = 1;
    bit   rv_manual = 1'b0;
    bit   rd_acc_seen = 1'b0;
    bit   mon_en = 1'b0;
    bit   pend = 1'b0;
    bit   prev_rd;
    logic [AW-1:0] prev_addr;
    logic [63:0]   prev_wd;
    int   hold = 0;
    bit   chk_hold = 1'b0;
    bit   first_acc = 1'b1;
    int   acc_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{rd: 1'b0, addr: AW'(i), wdata: 64'hdeadfadebabebeef ^ 64'(i)});
    endtask

    task automatic push_rd(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            exp_q.push_back('{rd: 1'b1, addr: AW'(i), wdata: 64'h0});
    endtask

    task automatic wait_empty(input string nm, input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout with %0d requests outstanding, want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic finish_check(input string nm, input int lat, input logic exp_fail);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk({nm, "_fin_early"}, is_finished, 64'd0);
            chk({nm, "_idle_req"}, avl.avl_write_req | avl.avl_read_req, 64'd0);
        end
        @(negedge clk);
        chk({nm, "_fin"}, is_finished, 64'd1);
        chk({nm, "_fail"}, fail, exp_fail);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; init_done = 1'b0; cal_succ = 1'b0; cal_fail = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    // Slave-side driver for avl_ready and avl_rdata_valid, updated just after each rising edge.
    initial begin
        int pc = 0;
        avl.avl_ready = 1'b0;
        avl.avl_rdata_valid = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0: avl.avl_ready = 1'b1;
                1: begin avl.avl_ready = (pc == 2); pc = (pc + 1) % 3; end
                default: avl.avl_ready = 1'b0;
            endcase
            if (rdy_mode != 1) pc = 0;
            avl.avl_rdata_valid = (rv_mode == 1) ? rd_acc_seen : rv_manual;
        end
    end

    // Monitor: pops the scoreboard on every accepted request and checks the handshake rules.
    always @(negedge clk) begin
        logic req;
        txn_t t;
        req = avl.avl_write_req | avl.avl_read_req;
        rd_acc_seen = avl.avl_read_req & avl.avl_ready;
        if (mon_en) begin
            if (req) begin
                chk("both_req", avl.avl_write_req & avl.avl_read_req, 64'd0);
                chk("burstbegin", avl.avl_burstbegin, {63'd0, !pend});
                if (pend) begin
                    chk("hold_kind", avl.avl_read_req, prev_rd);
                    chk("hold_addr", avl.avl_addr, prev_addr);
                    chk("hold_wdata", avl.avl_wdata, prev_wd);
                end
                hold++;
                if (avl.avl_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_accept: got addr %h rd %b, want no request",
                                 avl.avl_addr, avl.avl_read_req);
                    end else begin
                        t = exp_q.pop_front();
                        chk("acc_kind", avl.avl_read_req, t.rd);
                        chk("acc_addr", avl.avl_addr, t.addr);
                        chk("acc_wdata", avl.avl_wdata, t.wdata);
                        chk("acc_be", avl.avl_be, 64'hff);
                        chk("acc_size", avl.avl_size, 64'd1);
                    end
                    if (chk_hold && !first_acc) chk("hold_cycles", 64'(hold), 64'd3);
                    first_acc = 1'b0;
                    hold = 0;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    prev_rd = avl.avl_read_req;
                    prev_addr = avl.avl_addr;
                    prev_wd = avl.avl_wdata;
                end
            end else begin
                chk("bb_idle", avl.avl_burstbegin, 64'd0);
                pend = 1'b0;
                hold = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        // Test 1: reset state, then a full write/read pass with avl_ready held high.
        do_reset();
        @(negedge clk);
        chk("rst_fin", is_finished, 64'd0);
        chk("rst_fail", fail, 64'd0);
        chk("rst_req", avl.avl_write_req | avl.avl_read_req, 64'd0);
        chk("rst_bb", avl.avl_burstbegin, 64'd0);
        rdy_mode = 0;
        push_wr(8);
        push_rd(0, 7);
        repeat (3) @(posedge clk);
        #1;
        init_done = 1'b1;
        cal_succ = 1'b1;
        wait_empty("t1", 100);
        finish_check("t1", LAT, 1'b0);

        // Test 2: avl_ready toggled 0,0,1; every request held three cycles.
        do_reset();
        rdy_mode = 1;
        chk_hold = 1'b1;
        first_acc = 1'b1;
        a0 = acc_cnt;
        push_wr(8);
        push_rd(0, 7);
        @(posedge clk); #1;
        init_done = 1'b1;
        cal_succ = 1'b1;
        wait_empty("t2", 300);
        chk("t2_accepts", 64'(acc_cnt - a0), 64'd16);
        chk_hold = 1'b0;
        finish_check("t2", LAT, 1'b0);

        // Test 3: calibration failure.
        do_reset();
        rdy_mode = 0;
        @(posedge clk); #1;
        init_done = 1'b1;
        cal_fail = 1'b1;
        @(negedge clk);
        chk("t3_fin0", is_finished, 64'd0);
        @(negedge clk);
        chk("t3_fin1", is_finished, 64'd0);
        chk("t3_fail1", fail, 64'd0);
        @(negedge clk);
        chk("t3_fin2", is_finished, 64'd1);
        chk("t3_fail2", fail, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_noreq", avl.avl_write_req | avl.avl_read_req, 64'd0);
        end

        // Test 4: both cal flags (success wins), reset while write 4 is pending, then restart.
        do_reset();
        rdy_mode = 0;
        push_wr(4);
        @(posedge clk); #1;
        init_done = 1'b1;
        cal_succ = 1'b1;
        cal_fail = 1'b1;
        wait_empty("t4a", 50);
        #1;
        rdy_mode = 2;
        reset = 1'b1;
        init_done = 1'b0;
        cal_succ = 1'b0;
        cal_fail = 1'b0;
        @(negedge clk);
        chk("t4_wr4_req", avl.avl_write_req, 64'd1);
        chk("t4_wr4_addr", avl.avl_addr, 64'd4);
        chk("t4_wr4_data", avl.avl_wdata, 64'hdeadfadebabebeeb);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_drop_req", avl.avl_write_req | avl.avl_read_req, 64'd0);
        chk("t4_drop_bb", avl.avl_burstbegin, 64'd0);
        rdy_mode = 0;
        push_wr(8);
        push_rd(0, 7);
        @(posedge clk); #1;
        init_done = 1'b1;
        cal_succ = 1'b1;
        wait_empty("t4b", 100);
        finish_check("t4", LAT, 1'b0);

`ifdef DDR3_TRAFFIC_GEN_READ_CREDIT_EN
        // Test 5: credit limit of two with no returned data.
        do_reset();
        rv_mode = 0;
        rv_manual = 1'b0;
        rdy_mode = 0;
        push_wr(8);
        push_rd(0, 1);
        @(posedge clk); #1;
        init_done = 1'b1;
        cal_succ = 1'b1;
        wait_empty("t5a", 100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_stall", avl.avl_read_req, 64'd0);
        end
        push_rd(2, 2);
        @(posedge clk); #1;
        rv_manual = 1'b1;
        @(posedge clk); #1;
        rv_manual = 1'b0;
        wait_empty("t5b", 20);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_stall2", avl.avl_read_req, 64'd0);
        end

        // Test 6: read accept and rdata_valid together at one below the limit.
        @(posedge clk); #1;
        rdy_mode = 2;
        rv_manual = 1'b1;
        @(posedge clk); #1;
        push_rd(3, 3);
        rdy_mode = 0;
        @(posedge clk); #1;
        rdy_mode = 2;
        rv_manual = 1'b0;
        @(negedge clk);
        chk("t6_req_kept", avl.avl_read_req, 64'd1);
        chk("t6_addr", avl.avl_addr, 64'd4);
        push_rd(4, 7);
        @(posedge clk); #1;
        rv_manual = 1'b1;
        rdy_mode = 0;
        wait_empty("t6", 100);
        finish_check("t6", 2, 1'b0);
        rv_mode = 1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
